// File: rtl/dense_pkg.sv
// rtl/dense_pkg.sv - shared state type, default sizes and width helper for the dense operand feed
package dense_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_S,
    ST_HDR,
    ST_DATA,
    ST_GAP
  } feed_state_t;

  localparam int DENSE_ROWS   = 280;
  localparam int DENSE_FRAMES = 560;
  localparam int DENSE_W      = 32;

  // Counter/address width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/feed_ram.sv
// rtl/feed_ram.sv - one-write, one-synchronous-read column buffer for a single lane
module feed_ram
  import dense_pkg::*;
#(
  parameter int DATA_W = DENSE_W,
  parameter int DEPTH  = DENSE_ROWS,
  localparam int AW    = clog2_min1(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dense_feed.sv
// rtl/dense_feed.sv - header + column operand transmitter feeding the dense multiplier lanes
// DENSE_FEED_LOOP_EN: after the last frame restart at frame 0 in WAIT_S instead of going idle
module dense_feed
  import dense_pkg::*;
#(
  parameter int DATA_W     = DENSE_W,
  parameter int ROWS       = DENSE_ROWS,
  parameter int NUM_FRAMES = DENSE_FRAMES,
  parameter int FRAME_GAP  = 0,
  localparam int AW        = clog2_min1(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cb_we,
  input  logic [AW-1:0]     cb_addr,
  input  logic [DATA_W-1:0] cb_data1,
  input  logic [DATA_W-1:0] cb_data2,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data1,
  input  logic [DATA_W-1:0] s_data2,
  output logic [DATA_W-1:0] tx_data1,
  output logic [DATA_W-1:0] tx_data2,
  output logic              tx_valid,
  output logic              tx_sof,
  output logic              busy,
  output logic              done
);

  localparam int FW = clog2_min1(NUM_FRAMES + 1);
  localparam int GW = clog2_min1(FRAME_GAP + 1);

  feed_state_t       state_q;
  logic [AW-1:0]     beat_q;
  logic [FW-1:0]     frame_q;
  logic [GW-1:0]     gap_q;
  logic [DATA_W-1:0] hdr1_q, hdr2_q;
  logic              tx_valid_q, tx_sof_q, done_q;

  logic [DATA_W-1:0] rd1, rd2;
  logic [AW:0]       beat_inc;
  logic [AW-1:0]     rd_addr;
  logic              rd_en, ram_we, last_beat, gap_last, frame_end, run_complete;
  logic [FW-1:0]     frames_after;

  assign last_beat = (beat_q == AW'(ROWS - 1));
  assign beat_inc  = {1'b0, beat_q} + (AW+1)'(1);
  assign gap_last  = (int'(gap_q) == FRAME_GAP - 1);

  // Read address runs one beat ahead so the RAM output lines up with each DATA beat.
  assign rd_en   = (state_q == ST_HDR) || ((state_q == ST_DATA) && !last_beat);
  assign rd_addr = (state_q == ST_HDR) ? '0 : beat_inc[AW-1:0];
  assign ram_we  = cb_we && (state_q == ST_IDLE);

  assign frames_after = (state_q == ST_DATA) ? frame_q + FW'(1) : frame_q;
  assign run_complete = (frames_after == FW'(NUM_FRAMES));
  assign frame_end    = ((state_q == ST_DATA) && last_beat && (FRAME_GAP == 0)) ||
                        ((state_q == ST_GAP) && gap_last);

  feed_ram #(.DATA_W(DATA_W), .DEPTH(ROWS)) u_ram1 (
    .clk(clk), .we(ram_we), .waddr(cb_addr), .wdata(cb_data1),
    .re(rd_en), .raddr(rd_addr), .rdata(rd1)
  );

  feed_ram #(.DATA_W(DATA_W), .DEPTH(ROWS)) u_ram2 (
    .clk(clk), .we(ram_we), .waddr(cb_addr), .wdata(cb_data2),
    .re(rd_en), .raddr(rd_addr), .rdata(rd2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      frame_q    <= '0;
      gap_q      <= '0;
      hdr1_q     <= '0;
      hdr2_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_sof_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start) begin
          state_q <= ST_WAIT_S;
          frame_q <= '0;
        end
        ST_WAIT_S: if (s_valid) begin
          hdr1_q     <= s_data1;
          hdr2_q     <= s_data2;
          tx_valid_q <= 1'b1;
          tx_sof_q   <= 1'b1;
          state_q    <= ST_HDR;
        end
        ST_HDR: begin
          tx_sof_q <= 1'b0;
          state_q  <= ST_DATA;
        end
        ST_DATA: if (last_beat) begin
          beat_q     <= '0;
          frame_q    <= frames_after;
          tx_valid_q <= 1'b0;
          if (FRAME_GAP > 0) begin
            gap_q   <= '0;
            state_q <= ST_GAP;
          end
        end else begin
          beat_q <= beat_inc[AW-1:0];
        end
        ST_GAP: if (!gap_last) gap_q <= gap_q + GW'(1);
        default: state_q <= ST_IDLE;
      endcase

      // Shared end-of-frame decision, reached straight from DATA or after the gap.
      if (frame_end) begin
        if (!run_complete) begin
          state_q <= ST_WAIT_S;
        end else begin
          done_q <= 1'b1;
`ifdef DENSE_FEED_LOOP_EN
          state_q <= ST_WAIT_S;
          frame_q <= '0;
`else
          state_q <= ST_IDLE;
`endif
        end
      end
    end
  end

  assign s_ready  = (state_q == ST_WAIT_S);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign tx_valid = tx_valid_q;
  assign tx_sof   = tx_sof_q;
  assign tx_data1 = !tx_valid_q ? '0 : (tx_sof_q ? hdr1_q : rd1);
  assign tx_data2 = !tx_valid_q ? '0 : (tx_sof_q ? hdr2_q : rd2);

endmodule

// File: tb/tb_dense_feed.sv
// tb/tb_dense_feed.sv - randomized scoreboard bench for dense_feed (ROWS=4, NUM_FRAMES=2, FRAME_GAP=2)
// Build with DENSE_FEED_LOOP_EN to exercise the looping run instead of the default scenarios.
module tb_dense_feed;

  localparam int W    = 32;
  localparam int ROWS = 4;
  localparam int NF   = 2;
  localparam int GAP  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cb_we = 1'b0;
  logic [1:0]    cb_addr = '0;
  logic [W-1:0]  cb_data1 = '0, cb_data2 = '0;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic [W-1:0]  s_data1 = '0, s_data2 = '0;
  logic          s_ready, tx_valid, tx_sof, busy, done;
  logic [W-1:0]  tx_data1, tx_data2;

  always #5 clk = ~clk;

  dense_feed #(.DATA_W(W), .ROWS(ROWS), .NUM_FRAMES(NF), .FRAME_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .cb_we(cb_we), .cb_addr(cb_addr),
    .cb_data1(cb_data1), .cb_data2(cb_data2), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data1(s_data1), .s_data2(s_data2),
    .tx_data1(tx_data1), .tx_data2(tx_data2), .tx_valid(tx_valid),
    .tx_sof(tx_sof), .busy(busy), .done(done)
  );

  typedef struct packed {
    int           cyc;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic         sof;
  } beat_t;

  beat_t        exp_q[$];
  int           done_q[$];
  logic [W-1:0] m1 [ROWS];
  logic [W-1:0] m2 [ROWS];
  int           total = 0, bad = 0, cyc = 0, frame_idx = 0;
  bit           run_active = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every presented beat and done pulse must match the head of its queue.
  always @(negedge clk) begin : mon
    beat_t e;
    if (tx_valid) begin
      if (exp_q.size() == 0) chk("unexpected_beat", tx_valid, 0);
      else begin
        e = exp_q.pop_front();
        chk("beat_cycle", cyc, e.cyc);
        chk("beat_d1", tx_data1, e.d1);
        chk("beat_d2", tx_data2, e.d2);
        chk("beat_sof", tx_sof, e.sof);
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      chk("missing_beat", tx_valid, 1);
      e = exp_q.pop_front();
    end
    if (done) begin
      if (done_q.size() == 0) chk("unexpected_done", done, 0);
      else begin
        chk("done_cycle", cyc, done_q.pop_front());
        chk("busy_at_done", busy, 0);
      end
    end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
      chk("missing_done", done, 1);
      void'(done_q.pop_front());
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    exp_q.delete();
    done_q.delete();
    run_active = 1'b0;
    frame_idx = 0;
  endtask

  task automatic load(input int a, input logic [W-1:0] d1, input logic [W-1:0] d2);
    cb_we = 1'b1; cb_addr = a[1:0]; cb_data1 = d1; cb_data2 = d2;
    if (!run_active) begin m1[a] = d1; m2[a] = d2; end
    step();
    cb_we = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
    run_active = 1'b1;
    frame_idx = 0;
    chk("busy_after_start", busy, 1);
    chk("s_ready_after_start", s_ready, 1);
  endtask

  // Offers one scalar pair; on the handshake the whole expected frame is queued.
  task automatic run_frame(input int delay, input logic [W-1:0] a, input logic [W-1:0] b,
                           output int h);
    beat_t e;
    h = -1;
    if (delay > 0) begin
      for (int i = 0; i < 100 && !s_ready; i++) step();
      step(delay);
    end
    s_valid = 1'b1; s_data1 = a; s_data2 = b;
    for (int i = 0; i < 100 && !s_ready; i++) step();
    if (!s_ready) begin
      chk("s_ready_timeout", s_ready, 1);
    end else begin
      h = cyc;
      e.cyc = h + 1; e.d1 = a; e.d2 = b; e.sof = 1'b1;
      exp_q.push_back(e);
      for (int k = 0; k < ROWS; k++) begin
        e.cyc = h + 2 + k; e.d1 = m1[k]; e.d2 = m2[k]; e.sof = 1'b0;
        exp_q.push_back(e);
      end
      frame_idx++;
      if (frame_idx % NF == 0) done_q.push_back(h + 2 + ROWS + GAP);
      step();
    end
    s_valid = 1'b0;
  endtask

  task automatic finish_run();
    for (int i = 0; i < 200 && busy; i++) step();
    chk("run_end", busy, 0);
    run_active = 1'b0;
    step(3);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int h;
    do_reset();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_sof", tx_sof, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_tx_data1", tx_data1, 0);
    chk("rst_tx_data2", tx_data2, 0);

    for (int k = 0; k < ROWS; k++) load(k, W'(k + 1), W'(10 * (k + 1)));

`ifdef DENSE_FEED_LOOP_EN
    start_run();
    for (int f = 0; f < 5; f++) run_frame(0, W'(5 + f), W'(50 + f), h);
    step(ROWS + GAP + 4);
    chk("loop_waits_again", s_ready, 1);
    chk("loop_still_busy", busy, 1);
    do_reset();
`else
    // Basic two-frame run with s_valid offered early.
    start_run();
    run_frame(0, 5, 50, h);
    run_frame(0, 5, 50, h);
    finish_run();

    // Late scalars for frame 2 plus a dropped buffer write during frame 1.
    start_run();
    run_frame(0, 5, 50, h);
    step();
    load(0, 99, 99);
    run_frame(7, 6, 60, h);
    finish_run();

    // start while busy is ignored.
    start_run();
    run_frame(0, 7, 70, h);
    start = 1'b1; step(); start = 1'b0;
    run_frame(2, 8, 80, h);
    finish_run();
    step(10);
    chk("idle_after_extra_start", busy, 0);

    // Reset on the third DATA beat abandons the frame.
    start_run();
    run_frame(0, 9, 90, h);
    step(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    done_q.delete();
    run_active = 1'b0;
    chk("midrst_tx_valid", tx_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_tx_data1", tx_data1, 0);
    chk("midrst_tx_data2", tx_data2, 0);
    chk("midrst_s_ready", s_ready, 0);
    start_run();
    run_frame(0, 11, 110, h);
    run_frame(1, 12, 120, h);
    finish_run();

    // Randomized buffer contents, scalars and handshake delays.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < ROWS; k++) load(k, $urandom, $urandom);
      start_run();
      for (int f = 0; f < NF; f++) run_frame($urandom_range(0, 5), $urandom, $urandom, h);
      finish_run();
    end
`endif

    step(5);
    chk("leftover_beats", exp_q.size(), 0);
    chk("leftover_done", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
